// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: prefix and shift key
// codes, frame FSM states and the key event record stored in the FIFO.
// Optional build macro: PS2_SHIFT_TRACK_EN adds a shift bit to every event.
package ps2_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [7:0] LSHIFT     = 8'h12;
  localparam logic [7:0] RSHIFT     = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  // "release" is a reserved word, so the break flag is called released.
  typedef struct packed {
`ifdef PS2_SHIFT_TRACK_EN
    logic       shift;
`endif
    logic       extended;
    logic       released;
    logic [7:0] code;
  } ps2_event_t;

  localparam int EVT_W = $bits(ps2_event_t);

  // PS/2 frames use odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity_bit(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO with a registered head. The head register is loaded
// directly from the push data when the FIFO would otherwise be empty, so a
// pushed event is visible one clock after the push.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic                    head_valid,
  output logic [WIDTH-1:0]        head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_nxt_s;
  logic [AW:0]      count_r;
  logic [AW:0]      after_pop_s;
  logic [AW:0]      count_nxt_s;
  logic             valid_r;
  logic [WIDTH-1:0] head_r;
  logic             pop_s;
  logic             accept_s;
  logic             remain_s;

  // Pop is resolved before push so a full FIFO can accept while draining.
  always_comb begin
    pop_s        = pop & valid_r;
    accept_s     = push & ((count_r != FULL_CNT) | pop_s);
    after_pop_s  = count_r - (AW+1)'(pop_s);
    count_nxt_s  = after_pop_s + (AW+1)'(accept_s);
    rd_ptr_nxt_s = rd_ptr_r + AW'(pop_s);
    remain_s     = (after_pop_s != {(AW+1){1'b0}});
  end

  // Storage array write port; no reset needed on payload storage.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      valid_r  <= 1'b0;
      head_r   <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(accept_s);
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      valid_r  <= (count_nxt_s != {(AW+1){1'b0}});
      if (remain_s) begin
        head_r <= mem_r[rd_ptr_nxt_s];
      end else if (accept_s) begin
        head_r <= push_data;
      end else begin
        head_r <= head_r;
      end
    end
  end

  assign head_valid = valid_r;
  assign head_data  = head_r;
  assign count      = count_r;
  assign drop       = push & ~accept_s;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchroniser, ps2_clk glitch filter, 11-bit frame
// FSM with timeout, E0/F0 prefix folding and a key event FIFO.
// Optional build macro: PS2_SHIFT_TRACK_EN adds shift_held and evt_shift.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int FILTER_LEN     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ps2_clk,
  input  logic                         ps2_data,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [7:0]                   evt_code,
  output logic                         evt_release,
  output logic                         evt_extended,
  output logic                         frame_err,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
`ifdef PS2_SHIFT_TRACK_EN
  ,
  output logic                         shift_held,
  output logic                         evt_shift
`endif
);

  localparam int FCW = $clog2(FILTER_LEN) + 1;
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   clk_s;
  logic                   data_s;
  logic                   filt_r;
  logic [FCW-1:0]         filt_cnt_r;
  logic                   strobe_r;
  frame_state_t           state_r;
  logic [2:0]             bit_cnt_r;
  logic [7:0]             shift_r;
  logic                   par_err_r;
  logic [TCW-1:0]         tmo_cnt_r;
  logic                   byte_done_r;
  logic                   frame_err_r;
  logic                   ext_pend_r;
  logic                   rel_pend_r;
  logic                   overflow_r;
  logic                   push_s;
  logic                   drop_s;
  ps2_event_t             evt_s;
  ps2_event_t             head_s;
`ifdef PS2_SHIFT_TRACK_EN
  logic                   shift_held_r;
`endif

  assign clk_s  = clk_sync_r[SYNC_STAGES-1];
  assign data_s = data_sync_r[SYNC_STAGES-1];

  // Bring both PS/2 pins into the clk domain; idle bus level is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_r  <= {SYNC_STAGES{1'b1}};
      data_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Accept a ps2_clk level change only after FILTER_LEN differing samples;
  // an accepted falling edge yields the one-cycle bit strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_r     <= 1'b1;
      filt_cnt_r <= {FCW{1'b0}};
      strobe_r   <= 1'b0;
    end else if (clk_s != filt_r) begin
      if (filt_cnt_r == FILT_LAST) begin
        filt_r     <= clk_s;
        filt_cnt_r <= {FCW{1'b0}};
        strobe_r   <= ~clk_s;
      end else begin
        filt_cnt_r <= filt_cnt_r + {{(FCW-1){1'b0}}, 1'b1};
        strobe_r   <= 1'b0;
      end
    end else begin
      filt_cnt_r <= {FCW{1'b0}};
      strobe_r   <= 1'b0;
    end
  end

  // Frame FSM; a parity error is remembered and reported with the stop bit
  // so the trailing stop bit is never mistaken for a bad start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      par_err_r   <= 1'b0;
      tmo_cnt_r   <= {TCW{1'b0}};
      byte_done_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      byte_done_r <= 1'b0;
      frame_err_r <= 1'b0;
      if (strobe_r) begin
        tmo_cnt_r <= {TCW{1'b0}};
        case (state_r)
          ST_IDLE: begin
            if (data_s == 1'b0) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 3'd0;
              par_err_r <= 1'b0;
            end else begin
              frame_err_r <= 1'b1;
            end
          end
          ST_DATA: begin
            shift_r   <= {data_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end else begin
              state_r <= ST_DATA;
            end
          end
          ST_PARITY: begin
            par_err_r <= (data_s != odd_parity_bit(shift_r));
            state_r   <= ST_STOP;
          end
          ST_STOP: begin
            state_r <= ST_IDLE;
            if (data_s && !par_err_r) begin
              byte_done_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end else if (state_r == ST_IDLE) begin
        tmo_cnt_r <= {TCW{1'b0}};
      end else if (tmo_cnt_r == TMO_LAST) begin
        tmo_cnt_r   <= {TCW{1'b0}};
        frame_err_r <= 1'b1;
        state_r     <= ST_IDLE;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + {{(TCW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Build the event record; prefix bytes only update the pending flags.
  always_comb begin
    evt_s          = {EVT_W{1'b0}};
    evt_s.extended = ext_pend_r;
    evt_s.released = rel_pend_r;
    evt_s.code     = shift_r;
`ifdef PS2_SHIFT_TRACK_EN
    evt_s.shift    = shift_held_r;
`endif
    if (byte_done_r && (shift_r != EXT_CODE) && (shift_r != BREAK_CODE)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Prefix flags: set by E0/F0, cleared by a completed event or a frame error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_pend_r <= 1'b0;
      rel_pend_r <= 1'b0;
    end else if (frame_err_r || push_s) begin
      ext_pend_r <= 1'b0;
      rel_pend_r <= 1'b0;
    end else if (byte_done_r) begin
      ext_pend_r <= ext_pend_r | (shift_r == EXT_CODE);
      rel_pend_r <= rel_pend_r | (shift_r == BREAK_CODE);
    end else begin
      ext_pend_r <= ext_pend_r;
      rel_pend_r <= rel_pend_r;
    end
  end

`ifdef PS2_SHIFT_TRACK_EN
  // Shift state follows make/break of either shift key.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_held_r <= 1'b0;
    end else if (push_s && ((shift_r == LSHIFT) || (shift_r == RSHIFT))) begin
      shift_held_r <= ~rel_pend_r;
    end else begin
      shift_held_r <= shift_held_r;
    end
  end

  assign shift_held = shift_held_r;
  assign evt_shift  = head_s.shift;
`endif

  // Overflow stays set until reset once any event has been dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r | drop_s;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_data  (evt_s),
    .pop        (evt_ready),
    .head_valid (evt_valid),
    .head_data  (head_s),
    .count      (fifo_count),
    .drop       (drop_s)
  );

  assign evt_code     = head_s.code;
  assign evt_release  = head_s.released;
  assign evt_extended = head_s.extended;
  assign frame_err    = frame_err_r;
  assign overflow     = overflow_r;

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
Synthesizable PS/2 keyboard receiver and scan-code event decoder. It replaces the ad-hoc keyboard front end in the Motherboard and sits between the ps2_clk/ps2_data pins and the CPU/IO bus. It deserialises 11-bit frames, checks them, folds the F0 (break) and E0 (extended) prefixes into single key events, and buffers those events in a FIFO with a valid/ready handshake.

Parameters:
FIFO_DEPTH, 8, number of key events buffered; power of two, at least 2
SYNC_STAGES, 2, flip-flop stages on ps2_clk and ps2_data; at least 2
TIMEOUT_CYCLES, 10000, clk cycles without a falling ps2_clk edge before a partial frame is discarded
FILTER_LEN, 4, consecutive equal synced ps2_clk samples needed to accept a level change

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset; 0 = reset
ps2_clk  in  1  raw PS/2 clock pin
ps2_data  in  1  raw PS/2 data pin
evt_valid  out  1  FIFO head holds a key event
evt_ready  in  1  consumer accepts the head event
evt_code  out  8  scan code of the head event
evt_release  out  1  1 = key release (F0 prefix seen)
evt_extended  out  1  1 = E0 prefix seen
frame_err  out  1  one-cycle pulse on a parity, start or stop error, or a timeout
overflow  out  1  sticky; set when an event is dropped because the FIFO is full; cleared only by rst
fifo_count  out  $clog2(FIFO_DEPTH)+1  events currently stored

Behaviour:
- Reset (rst=0, async): all outputs 0, FIFO empty, frame FSM in IDLE, prefix flags cleared, filtered ps2_clk = 1.
- Input path: SYNC_STAGES synchroniser, then a glitch filter; the filtered level changes only after FILTER_LEN equal samples. A falling edge of the filtered clock produces a one-cycle sample strobe; ps2_data is sampled on that strobe.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: a strobe with data=0 moves to DATA and clears the bit counter; data=1 gives a start error and the FSM stays in IDLE.
  - DATA: eight strobes shift data in LSB first, then move to PARITY.
  - PARITY: the received bit must equal ~^data (odd parity). Move to STOP.
  - STOP: the bit must be 1. A good frame raises byte_done for one cycle. Any error pulses frame_err and returns to IDLE with no byte delivered.
- Timeout: in any state other than IDLE, a counter reloads on each strobe. Reaching TIMEOUT_CYCLES pulses frame_err and forces IDLE.
- Prefix decoder, acting on byte_done:
  - 0xE0 sets ext_pend.
  - 0xF0 sets rel_pend.
  - Any other byte forms the event {ext_pend, rel_pend, byte}, pushes it, then clears both pending flags.
  - A frame error also clears both pending flags.
- FIFO: push on an event when not full. If full, the event is dropped and overflow is set. Pop when evt_valid and evt_ready are both 1.
- Push and pop in the same cycle with the FIFO full: pop first, push accepted, count unchanged.
- Output timing: evt_* reflect the FIFO head registered. The first event is visible 1 clk after byte_done, i.e. 2 clk after the stop-bit strobe. evt_code, evt_release and evt_extended are held stable while evt_valid=1 and evt_ready=0.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.

Optional Feature:
PS2_SHIFT_TRACK_EN
- Defined: adds output port shift_held (1 bit). It is set by a make event of 0x12 or 0x59 and cleared by the matching release. Each pushed event carries an extra evt_shift bit, which is the shift_held value before that event is applied.
- Undefined: neither port exists and event width is 10 bits.

Decomposition:
- Package ps2_pkg holds:
  - constants BREAK_CODE=8'hF0, EXT_CODE=8'hE0, LSHIFT=8'h12, RSHIFT=8'h59
  - frame FSM state enum
  - packed struct ps2_event_t {extended, release, code}
- One sub-module: ps2_event_fifo, a parametrised synchronous FIFO with a registered head.

Test Plan:
1. Send frame 0x1C with correct parity (payload 0b1_0_00011100_0) -> one event: code=0x1C, release=0, extended=0; frame_err stays 0.
2. Send 0x1C, then 0xF0, then 0x1C -> two events: (0x1C, rel=0) then (0x1C, rel=1); fifo_count=2 before any pop.
3. Send 0x32 with the parity bit flipped -> frame_err pulses once, no event; a following good 0x21 produces (0x21, rel=0).
4. Send E0 F0 0x66 -> a single event: code=0x66, extended=1, release=1.
5. Hold evt_ready=0 and send 9 make codes with FIFO_DEPTH=8 -> fifo_count=8, overflow=1, head stays the first code. Raise evt_ready -> 8 events pop in order.
6. Stop after 4 data bits for TIMEOUT_CYCLES+1 cycles -> frame_err pulses, a following 0x23 frame decodes correctly. Assert rst mid-frame -> all outputs 0 immediately.
